sdram_sodimm_ctrl: RTL and testbench

//  Single-port SDRAM controller for the 64MB, 2-rank, 64-bit SDRAM SODIMM (4 banks, 4096 rows, 256 cols).

---
 rtl/sdram_ctrl_pkg.sv | 42 ++++
 rtl/sdram_sodimm_ctrl_if.sv | 40 ++++
 rtl/sdram_ref_timer.sv | 53 +++++
 rtl/sdram_sodimm_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_sdram_sodimm_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_ctrl_pkg.sv
// Shared definitions for the SODIMM SDRAM controller: DIMM command encodings,
// controller FSM states, host address field offsets and the mode-register word.
package sdram_ctrl_pkg;

    // {ras_n, cas_n, we_n}
    typedef enum logic [2:0] {
        CmdMrs = 3'b000,
        CmdRef = 3'b001,
        CmdPre = 3'b010,
        CmdAct = 3'b011,
        CmdWr  = 3'b100,
        CmdRd  = 3'b101,
        CmdNop = 3'b111
    } sd_cmd_e;

    typedef enum logic [3:0] {
        StInitWait,
        StInitPre,
        StInitRef1,
        StInitRef2,
        StInitMrs,
        StIdle,
        StRef,
        StRead,
        StWrite
    } state_e;

    // Host address layout: [22]=rank, [21:20]=bank, [19:8]=row, [7:0]=col
    localparam int unsigned HostAddrBits = 23;
    localparam int unsigned RankBit      = 22;
    localparam int unsigned BankLsb      = 20;
    localparam int unsigned RowLsb       = 8;
    localparam int unsigned ColLsb       = 0;

    // Burst length 1, sequential, CAS latency in A6:A4, standard operation.
    function automatic logic [11:0] mode_word(input int unsigned cas_lat);
        logic [2:0] cl;
        cl = cas_lat[2:0];
        mode_word = {5'b00000, cl, 1'b0, 3'b000};
    endfunction

endpackage

// File: rtl/sdram_sodimm_ctrl_if.sv
// Host request port plus DIMM command/data pins of the SDRAM controller.
//   slave  : controller side (drives ack/read data/DIMM pins, receives requests and DQ input)
//   master : host + DIMM side (drives requests and DQ input)
interface sdram_sodimm_ctrl_if #(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned DATA_BITS = 64
);
    logic                                    req;
    logic                                    req_we;
    logic [sdram_ctrl_pkg::HostAddrBits-1:0] req_addr;
    logic [DATA_BITS-1:0]                    req_wdata;
    logic [DATA_BITS/8-1:0]                  req_mask;
    logic                                    req_ack;
    logic                                    rd_valid;
    logic [DATA_BITS-1:0]                    rd_data;
    logic                                    init_done;
    logic [ADDR_BITS-1:0]                    sd_addr;
    logic [1:0]                              sd_ba;
    logic [1:0]                              sd_cke;
    logic [1:0]                              sd_cs_n;
    logic                                    sd_ras_n;
    logic                                    sd_cas_n;
    logic                                    sd_we_n;
    logic [DATA_BITS/8-1:0]                  sd_dqm;
    logic [DATA_BITS-1:0]                    sd_dq_out;
    logic                                    sd_dq_oe;
    logic [DATA_BITS-1:0]                    sd_dq_in;

    modport slave (
        input  req, req_we, req_addr, req_wdata, req_mask, sd_dq_in,
        output req_ack, rd_valid, rd_data, init_done, sd_addr, sd_ba, sd_cke, sd_cs_n,
               sd_ras_n, sd_cas_n, sd_we_n, sd_dqm, sd_dq_out, sd_dq_oe
    );

    modport master (
        output req, req_we, req_addr, req_wdata, req_mask, sd_dq_in,
        input  req_ack, rd_valid, rd_data, init_done, sd_addr, sd_ba, sd_cke, sd_cs_n,
               sd_ras_n, sd_cas_n, sd_we_n, sd_dqm, sd_dq_out, sd_dq_oe
    );
endinterface

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer. Loads REF_INTERVAL-1 on start, counts down, reloads at 0
// and raises pending. pending saturates and clears on ack.
//   clk, rst_n : clock, async active-low reset
//   start      : one-cycle pulse when init completes
//   ack        : refresh issued this cycle
//   pending    : refresh owed
module sdram_ref_timer #(
    parameter int unsigned REF_INTERVAL = 1560
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ack,
    output logic pending
);
    localparam int unsigned     CntW   = $clog2(REF_INTERVAL + 1);
    localparam logic [CntW-1:0] Reload = CntW'(REF_INTERVAL - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            running_q, running_d;
    logic            pending_q, pending_d;
    logic            expire;

    always_comb begin
        cnt_d     = cnt_q;
        running_d = running_q;
        pending_d = pending_q;
        expire    = running_q && !start && (cnt_q == '0);
        if (start) begin
            cnt_d     = Reload;
            running_d = 1'b1;
        end else if (running_q) begin
            cnt_d = expire ? Reload : cnt_q - 1'b1;
        end
        if (ack) pending_d = 1'b0;
        // An expiry in the same cycle as the ack is a new, separate request.
        if (expire) pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            running_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            running_q <= running_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
endmodule

// File: rtl/sdram_sodimm_ctrl.sv
// Closed-page SDRAM controller for a 2-rank 64-bit SODIMM: power-up init, periodic
// auto-refresh and single 64-bit accesses (ACT then RD/WR with auto-precharge).
//   clk, rst_n : controller/DIMM clock, async active-low reset
//   bus        : host request port and DIMM pins (slave modport); all outputs registered
module sdram_sodimm_ctrl
    import sdram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 12,
    parameter int unsigned COL_BITS     = 8,
    parameter int unsigned DATA_BITS    = 64,
    parameter int unsigned CAS_LAT      = 2,
    parameter int unsigned T_RCD        = 2,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_RC         = 7,
    parameter int unsigned T_WR         = 2,
    parameter int unsigned T_MRD        = 2,
    parameter int unsigned INIT_WAIT    = 20000,
    parameter int unsigned REF_INTERVAL = 1560
) (
    input logic               clk,
    input logic               rst_n,
    sdram_sodimm_ctrl_if.slave bus
);
    localparam int unsigned MaskBits = DATA_BITS / 8;
    localparam int unsigned WrCycles = (T_RC > T_RCD + T_WR + T_RP) ? T_RC : T_RCD + T_WR + T_RP;
    // Wait-counter end values; cnt_q is 0 in the cycle after a command is issued.
    localparam logic [15:0] InitEnd = 16'(INIT_WAIT);
    localparam logic [15:0] RpEnd   = 16'(T_RP - 1);
    localparam logic [15:0] RcEnd   = 16'(T_RC - 1);
    localparam logic [15:0] MrdEnd  = 16'(T_MRD - 1);
    localparam logic [15:0] RcdEnd  = 16'(T_RCD - 1);
    localparam logic [15:0] CapEnd  = 16'(T_RCD + CAS_LAT);
    localparam logic [15:0] WrEnd   = 16'(WrCycles - 1);

    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [1:0]             cke_q, cke_d, cs_n_q, cs_n_d, ba_q, ba_d;
    sd_cmd_e                cmd_q, cmd_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [MaskBits-1:0]    dqm_q, dqm_d, acc_mask_q, acc_mask_d;
    logic [DATA_BITS-1:0]   dq_out_q, dq_out_d, rd_data_q, rd_data_d, acc_wdata_q, acc_wdata_d;
    logic                   dq_oe_q, dq_oe_d, req_ack_q, req_ack_d, rd_valid_q, rd_valid_d;
    logic                   init_done_q, init_done_d, acc_rank_q, acc_rank_d;
    logic [1:0]             acc_bank_q, acc_bank_d;
    logic [COL_BITS-1:0]    acc_col_q, acc_col_d;
    logic                   sched, ref_ack, ref_pending;

    sdram_ref_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_ref_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (init_done_d & ~init_done_q),
        .ack    (ref_ack),
        .pending(ref_pending)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        cke_d       = 2'b11;
        cs_n_d      = 2'b11;
        cmd_d       = CmdNop;
        addr_d      = '0;
        ba_d        = '0;
        dqm_d       = init_done_q ? '0 : '1;
        dq_out_d    = '0;
        dq_oe_d     = 1'b0;
        req_ack_d   = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        init_done_d = init_done_q;
        acc_rank_d  = acc_rank_q;
        acc_bank_d  = acc_bank_q;
        acc_col_d   = acc_col_q;
        acc_wdata_d = acc_wdata_q;
        acc_mask_d  = acc_mask_q;
        ref_ack     = 1'b0;
        sched       = 1'b0;

        unique case (state_q)
            StInitWait: if (cnt_q == InitEnd) begin
                state_d    = StInitPre;
                cnt_d      = '0;
                cs_n_d     = 2'b00;
                cmd_d      = CmdPre;
                addr_d[10] = 1'b1;
            end
            StInitPre: if (cnt_q == RpEnd) begin
                state_d = StInitRef1;
                cnt_d   = '0;
                cs_n_d  = 2'b00;
                cmd_d   = CmdRef;
            end
            StInitRef1: if (cnt_q == RcEnd) begin
                state_d = StInitRef2;
                cnt_d   = '0;
                cs_n_d  = 2'b00;
                cmd_d   = CmdRef;
            end
            StInitRef2: if (cnt_q == RcEnd) begin
                state_d = StInitMrs;
                cnt_d   = '0;
                cs_n_d  = 2'b00;
                cmd_d   = CmdMrs;
                addr_d  = ADDR_BITS'(mode_word(CAS_LAT));
            end
            StInitMrs: if (cnt_q == MrdEnd) begin
                init_done_d = 1'b1;
                dqm_d       = '0;
                sched       = 1'b1;
            end
            StIdle: sched = 1'b1;
            StRef:  sched = (cnt_q == RcEnd);
            StRead: begin
                if (cnt_q == RcdEnd) begin
                    cs_n_d[acc_rank_q]   = 1'b0;
                    cmd_d                = CmdRd;
                    ba_d                 = acc_bank_q;
                    addr_d[10]           = 1'b1;
                    addr_d[COL_BITS-1:0] = acc_col_q;
                end
                // Data on the pins during cycle T_RCD+CAS_LAT lands in rd_data_q here.
                if (cnt_q == CapEnd) begin
                    rd_data_d  = bus.sd_dq_in;
                    rd_valid_d = 1'b1;
                end
                sched = (cnt_q == RcEnd);
            end
            StWrite: begin
                if (cnt_q == RcdEnd) begin
                    cs_n_d[acc_rank_q]   = 1'b0;
                    cmd_d                = CmdWr;
                    ba_d                 = acc_bank_q;
                    addr_d[10]           = 1'b1;
                    addr_d[COL_BITS-1:0] = acc_col_q;
                    dq_oe_d              = 1'b1;
                    dq_out_d             = acc_wdata_q;
                    dqm_d                = acc_mask_q;
                end
                sched = (cnt_q == WrEnd);
            end
            default: state_d = StIdle;
        endcase

        // Idle decision, also taken in the last cycle of a wait so back-to-back work
        // starts exactly when the previous timing window closes.
        if (sched) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (ref_pending) begin
                state_d = StRef;
                cs_n_d  = 2'b00;
                cmd_d   = CmdRef;
                ref_ack = 1'b1;
            end else if (bus.req) begin
                state_d                     = bus.req_we ? StWrite : StRead;
                cs_n_d[bus.req_addr[RankBit]] = 1'b0;
                cmd_d                       = CmdAct;
                ba_d                        = bus.req_addr[BankLsb +: 2];
                addr_d                      = bus.req_addr[RowLsb +: ADDR_BITS];
                req_ack_d                   = 1'b1;
                acc_rank_d                  = bus.req_addr[RankBit];
                acc_bank_d                  = bus.req_addr[BankLsb +: 2];
                acc_col_d                   = bus.req_addr[ColLsb +: COL_BITS];
                acc_wdata_d                 = bus.req_wdata;
                acc_mask_d                  = bus.req_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInitWait;
            cnt_q       <= '0;
            cke_q       <= 2'b00;
            cs_n_q      <= 2'b11;
            cmd_q       <= CmdNop;
            addr_q      <= '0;
            ba_q        <= '0;
            dqm_q       <= '1;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            req_ack_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            init_done_q <= 1'b0;
            acc_rank_q  <= 1'b0;
            acc_bank_q  <= '0;
            acc_col_q   <= '0;
            acc_wdata_q <= '0;
            acc_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cke_q       <= cke_d;
            cs_n_q      <= cs_n_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            ba_q        <= ba_d;
            dqm_q       <= dqm_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            req_ack_q   <= req_ack_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            init_done_q <= init_done_d;
            acc_rank_q  <= acc_rank_d;
            acc_bank_q  <= acc_bank_d;
            acc_col_q   <= acc_col_d;
            acc_wdata_q <= acc_wdata_d;
            acc_mask_q  <= acc_mask_d;
        end
    end

    assign bus.sd_cke                                = cke_q;
    assign bus.sd_cs_n                               = cs_n_q;
    assign {bus.sd_ras_n, bus.sd_cas_n, bus.sd_we_n} = cmd_q;
    assign bus.sd_addr                               = addr_q;
    assign bus.sd_ba                                 = ba_q;
    assign bus.sd_dqm                                = dqm_q;
    assign bus.sd_dq_out                             = dq_out_q;
    assign bus.sd_dq_oe                              = dq_oe_q;
    assign bus.req_ack                               = req_ack_q;
    assign bus.rd_valid                              = rd_valid_q;
    assign bus.rd_data                               = rd_data_q;
    assign bus.init_done                             = init_done_q;
endmodule

// File: tb/tb_sdram_sodimm_ctrl.sv
// Bench for sdram_sodimm_ctrl with a small behavioural DIMM model (CL=2) and a read
// scoreboard: expected read data is queued at request time and checked by a monitor.
module tb_sdram_sodimm_ctrl;
    import sdram_ctrl_pkg::*;

    localparam int unsigned InitWait    = 10;
    localparam int unsigned RefInterval = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    sdram_sodimm_ctrl_if bus ();

    sdram_sodimm_ctrl #(
        .INIT_WAIT   (InitWait),
        .REF_INTERVAL(RefInterval)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- DIMM model ----------------
    // Memory indexed by {rank, bank, row[3:0], col[3:0]}; test addresses differ in these bits.
    logic [63:0] mem [2048];
    logic [11:0] open_row [8];
    logic        rd_pend = 1'b0;
    logic [10:0] rd_key;

    always @(posedge clk) begin
        logic [2:0]  c;
        logic        rk;
        logic [10:0] key;
        logic [63:0] word;
        bus.sd_dq_in <= rd_pend ? mem[rd_key] : 64'h5A5A_5A5A_5A5A_5A5A;
        rd_pend      <= 1'b0;
        c   = {bus.sd_ras_n, bus.sd_cas_n, bus.sd_we_n};
        rk  = (bus.sd_cs_n == 2'b01);
        key = {rk, bus.sd_ba, open_row[{rk, bus.sd_ba}][3:0], bus.sd_addr[3:0]};
        if (bus.sd_cs_n != 2'b11 && bus.sd_cke == 2'b11) begin
            if (c == CmdAct) open_row[{rk, bus.sd_ba}] <= bus.sd_addr;
            if (c == CmdRd && bus.sd_addr[10]) begin
                rd_pend <= 1'b1;
                rd_key  <= key;
            end
            if (c == CmdWr && bus.sd_addr[10] && bus.sd_dq_oe) begin
                word = mem[key];
                for (int b = 0; b < 8; b++)
                    if (!bus.sd_dqm[b]) word[8*b +: 8] = bus.sd_dq_out[8*b +: 8];
                mem[key] <= word;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [63:0] exp_q [$];
    int unsigned ack_q [$];
    int unsigned last_ref_cyc = 0;

    always @(negedge clk) begin
        int unsigned a;
        if (!rst_n) begin
            ack_q.delete();
        end else begin
            if (bus.req_ack && !bus.req_we) ack_q.push_back(cyc);
            if (bus.init_done && bus.sd_cs_n == 2'b00 &&
                {bus.sd_ras_n, bus.sd_cas_n, bus.sd_we_n} == CmdRef)
                last_ref_cyc = cyc;
            if (bus.rd_valid) begin
                if (exp_q.size() == 0 || ack_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rd_valid: got rd_valid=1 data %h, expected none",
                             bus.rd_data);
                end else begin
                    a = ack_q.pop_front();
                    check("rd_latency", 64'(cyc - a), 64'd5);
                    check("rd_data", bus.rd_data, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_vals(input string name);
        check({name, "_ctrl"},
              {bus.sd_cke, bus.sd_cs_n, bus.sd_ras_n, bus.sd_cas_n, bus.sd_we_n, bus.sd_dqm,
               bus.sd_dq_oe, bus.sd_ba, bus.req_ack, bus.rd_valid, bus.init_done},
              {2'b00, 2'b11, 3'b111, 8'hFF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
        check({name, "_addr"}, bus.sd_addr, 64'h0);
        check({name, "_data"}, bus.sd_dq_out | bus.rd_data, 64'h0);
    endtask

    task automatic wait_cmd(output logic [4:0] cc, output logic [11:0] a, output logic [1:0] ba,
                            output int unsigned tc);
        tc = 0;
        cc = 5'h1F;
        a  = '0;
        ba = '0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.sd_cs_n != 2'b11) begin
                cc = {bus.sd_cs_n, bus.sd_ras_n, bus.sd_cas_n, bus.sd_we_n};
                a  = bus.sd_addr;
                ba = bus.sd_ba;
                tc = cyc;
                break;
            end
        end
        if (tc == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_timeout: got no command, expected one within 500 cycles");
        end
    endtask

    task automatic check_init(output int unsigned done_cyc);
        int unsigned c0, t0, t1;
        logic [4:0]  cc;
        logic [11:0] a;
        logic [1:0]  ba;
        for (int i = 0; i < 5 && bus.sd_cke != 2'b11; i++) @(negedge clk);
        check("init_cke", bus.sd_cke, 2'b11);
        c0 = cyc;
        wait_cmd(cc, a, ba, t0);
        check("init_pre_cmd", {cc, a[10]}, {2'b00, CmdPre, 1'b1});
        check("init_pre_cycle", 64'(t0 - c0), 64'd10);
        wait_cmd(cc, a, ba, t1);
        check("init_ref1", {cc, 32'(t1 - t0)}, {2'b00, CmdRef, 32'd2});
        wait_cmd(cc, a, ba, t0);
        check("init_ref2", {cc, 32'(t0 - t1)}, {2'b00, CmdRef, 32'd7});
        wait_cmd(cc, a, ba, t1);
        check("init_mrs", {cc, ba, a, 32'(t1 - t0)}, {2'b00, CmdMrs, 2'b00, 12'h020, 32'd7});
        @(negedge clk);
        check("init_done_early", bus.init_done, 1'b0);
        @(negedge clk);
        check("init_done_mrs2", {bus.init_done, bus.sd_dqm}, {1'b1, 8'h00});
        done_cyc = cyc;
    endtask

    task automatic do_req(input logic we, input logic [22:0] addr, input logic [63:0] wd,
                          input logic [7:0] mask, input logic push_exp, input logic [63:0] exp,
                          output int unsigned ack_cyc, output logic [1:0] act_cs);
        if (!we && push_exp) exp_q.push_back(exp);
        bus.req       = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_mask  = mask;
        ack_cyc = 0;
        act_cs  = 2'b11;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (bus.req_ack) begin
                ack_cyc = cyc;
                act_cs  = bus.sd_cs_n;
                break;
            end
        end
        bus.req = 1'b0;
        if (ack_cyc == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ack_timeout: got no ack, expected one within 400 cycles");
        end
    endtask

    // ---------------- main sequence ----------------
    localparam logic [22:0] A0 = 23'h0A1234;  // rank 0, bank 0, row A12, col 34
    localparam logic [22:0] A1 = 23'h0B5678;
    localparam logic [22:0] A2 = 23'h1C9ABC;  // bank 1
    localparam logic [22:0] A3 = 23'h4A1234;  // rank 1, same offset as A0
    localparam logic [63:0] D0 = 64'hDEADBEEF_01234567;
    localparam logic [63:0] D3 = 64'h01234567_89ABCDEF;

    initial begin
        int unsigned done_cyc, aw, ar, p;
        logic [1:0]  cs;
        bus.req = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_mask = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        #2 rst_n = 1'b1;
        check_init(done_cyc);

        // Write then read back; back-to-back gaps follow T_RC / write window.
        do_req(1'b1, A0, D0, 8'h00, 1'b0, '0, aw, cs);
        check("act_cs_rank0", cs, 2'b10);
        do_req(1'b0, A0, '0, 8'h00, 1'b1, D0, ar, cs);
        check("wr_to_rd_gap", 64'(ar - aw), 64'd7);

        // Byte masks: mask bit i protects data byte i.
        do_req(1'b1, A1, '1, 8'h00, 1'b0, '0, aw, cs);
        check("rd_to_wr_gap", 64'(aw - ar), 64'd7);
        do_req(1'b1, A1, '0, 8'h0F, 1'b0, '0, aw, cs);
        do_req(1'b0, A1, '0, 8'h00, 1'b1, 64'h00000000_FFFFFFFF, ar, cs);
        do_req(1'b1, A2, '1, 8'h00, 1'b0, '0, aw, cs);
        do_req(1'b1, A2, '0, 8'hF0, 1'b0, '0, aw, cs);
        do_req(1'b0, A2, '0, 8'h00, 1'b1, 64'hFFFFFFFF_00000000, ar, cs);

        // Rank 1 selects cs_n[1] and leaves rank 0 data alone.
        do_req(1'b1, A3, D3, 8'h00, 1'b0, '0, aw, cs);
        check("act_cs_rank1", cs, 2'b01);
        do_req(1'b0, A3, '0, 8'h00, 1'b1, D3, ar, cs);
        do_req(1'b0, A0, '0, 8'h00, 1'b1, D0, ar, cs);

        // Raise Req in the cycle the refresh timer expires: REF wins, ACT waits T_RC.
        p = done_cyc + RefInterval;
        while (p < cyc + 3) p += RefInterval;
        for (int i = 0; i < 1000 && cyc != p; i++) @(negedge clk);
        #2;
        do_req(1'b0, A0, '0, 8'h00, 1'b1, D0, ar, cs);
        check("ref_first_cycle", 64'(last_ref_cyc), 64'(p + 1));
        check("ack_after_ref", 64'(ar - last_ref_cyc), 64'd7);
        for (int i = 0; i < 300 && cyc < p + RefInterval + 5; i++) @(negedge clk);
        check("ref_period", 64'(last_ref_cyc), 64'(p + RefInterval + 1));

        // Reset one cycle after a read ACT: outputs drop at once and the read never returns.
        do_req(1'b0, A0, '0, 8'h00, 1'b0, '0, ar, cs);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        repeat (6) @(negedge clk);
        check_reset_vals("heldreset");
        #2 rst_n = 1'b1;
        check_init(done_cyc);
        do_req(1'b0, A0, '0, 8'h00, 1'b1, D0, ar, cs);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish before 20000 cycles");
        $fatal(1);
    end
endmodule
